zero_line_page_compressor: RTL

- Parametrised successor to the fixed-size cache-line compressor in the HACD comp/decomp path.
- Compresses one page of NUM_LINES cache lines held in the read FIFO using zero-line elision.
- Pass 1 scans the page and builds a per-line nonzero bitmap. The block then writes one header line, re-reads the page, and forwards only nonzero lines to the write FIFO.
- Flags the page incompressible when the nonzero-line count exceeds a threshold, and on read errors.

---
 rtl/zero_line_page_compressor.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/zero_line_page_compressor.sv
// Zero-line elision page compressor: scans a page to build a nonzero-line bitmap,
// emits a header line, then re-reads the page and forwards only nonzero lines.
module zero_line_page_compressor #(
  parameter int unsigned FIFO_PTR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned NUM_LINES      = 64,
  parameter int unsigned MAX_NZ_LINES   = 62,
  parameter int unsigned SIZE_WIDTH     = 14
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      comp_start,
  output logic [SIZE_WIDTH-1:0]     comp_size,
  output logic [FIFO_PTR_WIDTH-1:0] rdfifo_rdptr,
  output logic                      ld_rdfifo_rdptr,
  input  logic                      rdfifo_empty,
  output logic                      rd_req,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  input  logic [1:0]                rd_rresp,
  input  logic                      rd_valid,
  input  logic                      wrfifo_full,
  output logic                      wr_req,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      incompressible,
  output logic                      comp_done,
  output logic                      rd_err,
  output logic [2:0]                dbg_state
);

  localparam int unsigned CNT_W      = FIFO_PTR_WIDTH + 1;
  localparam int unsigned LINE_BYTES = DATA_WIDTH / 8;
  localparam int unsigned PAGE_BYTES = NUM_LINES * LINE_BYTES;

  localparam logic [CNT_W-1:0]      LAST_IDX  = CNT_W'(NUM_LINES - 1);
  localparam logic [CNT_W-1:0]      END_IDX   = CNT_W'(NUM_LINES);
  localparam logic [CNT_W-1:0]      MAX_NZ    = CNT_W'(MAX_NZ_LINES);
  localparam logic [SIZE_WIDTH-1:0] PAGE_SIZE = SIZE_WIDTH'(PAGE_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD1 = 3'd1,
    ST_SCAN  = 3'd2,
    ST_HDR   = 3'd3,
    ST_LOAD2 = 3'd4,
    ST_COPY  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_LINES-1:0]      bitmap_q;
  logic [CNT_W-1:0]          nz_cnt_q;
  logic [CNT_W-1:0]          idx_q;
  logic [DATA_WIDTH-1:0]     hold_q;
  logic                      hold_valid_q;

  logic                      beat_c;
  logic                      line_nz_c;
  logic                      beat_err_c;
  logic                      enter_done_c;
  logic                      done_incomp_c;
  logic                      set_err_c;
  logic [CNT_W-1:0]          nz_inc_c;
  logic [CNT_W-1:0]          idx_inc_c;
  logic [FIFO_PTR_WIDTH-1:0] idx_ptr_c;
  logic [DATA_WIDTH-1:0]     hdr_c;
  logic [SIZE_WIDTH-1:0]     ok_size_c;

  assign rdfifo_rdptr = '0;
  assign dbg_state    = state_q;

  // Per-beat arithmetic shared by both passes
  always_comb begin
    line_nz_c  = |rd_data;
    beat_err_c = (rd_rresp != 2'b00);
    nz_inc_c   = nz_cnt_q + CNT_W'(line_nz_c);
    idx_inc_c  = (idx_q == END_IDX) ? idx_q : idx_q + CNT_W'(1);
    idx_ptr_c  = FIFO_PTR_WIDTH'(idx_q);
    ok_size_c  = SIZE_WIDTH'((32'(nz_cnt_q) + 32'd1) * 32'(LINE_BYTES));
    hdr_c                      = '0;
    hdr_c[NUM_LINES-1:0]       = bitmap_q;
    hdr_c[NUM_LINES +: CNT_W]  = nz_cnt_q;
  end

  // Next-state and handshake decode
  always_comb begin
    state_d         = state_q;
    rd_req          = 1'b0;
    wr_req          = 1'b0;
    wr_data         = '0;
    ld_rdfifo_rdptr = 1'b0;
    comp_done       = 1'b0;
    beat_c          = 1'b0;
    enter_done_c    = 1'b0;
    done_incomp_c   = 1'b0;
    set_err_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (comp_start) state_d = ST_LOAD1;
      end
      ST_LOAD1: begin
        ld_rdfifo_rdptr = 1'b1;
        state_d         = ST_SCAN;
      end
      ST_SCAN: begin
        rd_req = !rdfifo_empty;
        beat_c = rd_req && rd_valid;
        if (beat_c) begin
          if (beat_err_c) begin
            set_err_c     = 1'b1;
            enter_done_c  = 1'b1;
            done_incomp_c = 1'b1;
            state_d       = ST_DONE;
          end else if (idx_q == LAST_IDX) begin
            if (nz_inc_c > MAX_NZ) begin
              enter_done_c  = 1'b1;
              done_incomp_c = 1'b1;
              state_d       = ST_DONE;
            end else begin
              state_d = ST_HDR;
            end
          end
        end
      end
      ST_HDR: begin
        wr_req  = !wrfifo_full;
        wr_data = hdr_c;
        if (wr_req) state_d = ST_LOAD2;
      end
      ST_LOAD2: begin
        ld_rdfifo_rdptr = 1'b1;
        state_d         = ST_COPY;
      end
      ST_COPY: begin
        // Reads stop once the page is exhausted so a deeper FIFO is never over-read
        rd_req  = !rdfifo_empty && !hold_valid_q && (idx_q != END_IDX);
        beat_c  = rd_req && rd_valid;
        wr_req  = hold_valid_q && !wrfifo_full;
        wr_data = hold_q;
        if (beat_c && beat_err_c) begin
          set_err_c     = 1'b1;
          enter_done_c  = 1'b1;
          done_incomp_c = 1'b1;
          state_d       = ST_DONE;
        end else if (idx_q == END_IDX && !hold_valid_q) begin
          enter_done_c = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        comp_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      bitmap_q       <= '0;
      nz_cnt_q       <= '0;
      idx_q          <= '0;
      hold_q         <= '0;
      hold_valid_q   <= 1'b0;
      incompressible <= 1'b0;
      rd_err         <= 1'b0;
      comp_size      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (comp_start) begin
            bitmap_q       <= '0;
            nz_cnt_q       <= '0;
            idx_q          <= '0;
            hold_valid_q   <= 1'b0;
            incompressible <= 1'b0;
            rd_err         <= 1'b0;
            comp_size      <= '0;
          end
        end
        ST_SCAN: begin
          if (beat_c && !beat_err_c) begin
            bitmap_q[idx_ptr_c] <= line_nz_c;
            nz_cnt_q            <= nz_inc_c;
            idx_q               <= idx_inc_c;
          end
        end
        ST_LOAD2: idx_q <= '0;
        ST_COPY: begin
          // The SCAN bitmap decides which lines survive; COPY data is not rechecked
          if (beat_c && !beat_err_c) begin
            if (bitmap_q[idx_ptr_c]) begin
              hold_q       <= rd_data;
              hold_valid_q <= 1'b1;
            end
            idx_q <= idx_inc_c;
          end
          if (wr_req) hold_valid_q <= 1'b0;
        end
        default: ;
      endcase
      if (enter_done_c) begin
        incompressible <= done_incomp_c;
        comp_size      <= done_incomp_c ? PAGE_SIZE : ok_size_c;
        if (set_err_c) rd_err <= 1'b1;
      end
    end
  end

endmodule
